// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit:
// funct3 encodings, FSM states and store lane-mask helper.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_e;

    // Byte-enable mask for an access of 2**size bytes at byte offset off.
    function automatic logic [7:0] lane_mask(input logic [1:0] size,
                                             input logic [2:0] off);
        logic [7:0] m;
        case (size)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            2'b10:   m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m << off;
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks the addressed lanes out of a bus word
// and sign- or zero-extends them according to funct3.
module load_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata_i,
    input  logic [2:0]      funct3_i,
    input  logic [2:0]      off_i,
    output logic [XLEN-1:0] data_o
);

    logic [XLEN-1:0] sh;

    // Shift the addressed byte down to lane 0, then extend.
    always_comb begin
        sh     = rdata_i >> {off_i, 3'b000};
        data_o = '0;
        case (funct3_i)
            F3_B:    data_o = XLEN'($signed(sh[7:0]));
            F3_H:    data_o = XLEN'($signed(sh[15:0]));
            F3_W:    data_o = XLEN'($signed(sh[31:0]));
            F3_BU:   data_o = XLEN'(sh[7:0]);
            F3_HU:   data_o = XLEN'(sh[15:0]);
            F3_WU:   data_o = XLEN'(sh[31:0]);
            F3_D:    data_o = sh;
            default: data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: accepts one op from execute, runs a req/gnt/rvalid bus
// transaction for loads/stores, and returns a one-cycle writeback pulse.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ex_valid,
    output logic                ex_ready,
    input  logic                ex_is_load,
    input  logic                ex_is_store,
    input  logic [2:0]          ex_funct3,
    input  logic [ADDR_W-1:0]   ex_addr,
    input  logic [XLEN-1:0]     ex_wdata,
    input  logic [4:0]          ex_rd,
    output logic                wb_valid,
    output logic                wb_we,
    output logic                wb_err,
    output logic [XLEN-1:0]     wb_data,
    output logic [4:0]          wb_rd,
    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [XLEN-1:0]     bus_wdata,
    output logic [XLEN/8-1:0]   bus_wmask,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic                bus_err,
    input  logic [XLEN-1:0]     bus_rdata
);

    localparam int  NB    = XLEN / 8;
    localparam int  OFF_W = $clog2(NB);
    localparam int  CNT_W = $clog2(MAX_WAIT + 1);
    localparam bit  IS64  = (XLEN == 64);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              ld_q;
    logic [2:0]        f3_q;
    logic [2:0]        off_q;

    logic              bus_req_q;
    logic              bus_we_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [XLEN-1:0]   bus_wdata_q;
    logic [NB-1:0]     bus_wmask_q;
    logic              wb_valid_q;
    logic              wb_we_q;
    logic              wb_err_q;
    logic [XLEN-1:0]   wb_data_q;
    logic [4:0]        wb_rd_q;

    logic              ld;
    logic              mem;
    logic              f3_ok;
    logic              misal;
    logic [2:0]        off3;
    logic [XLEN-1:0]   wrep;
    logic [XLEN-1:0]   ld_data;
    int                nb;

    assign ld   = ex_is_load & ~ex_is_store;
    assign mem  = ex_is_load | ex_is_store;
    assign off3 = 3'(ex_addr[OFF_W-1:0]);

    // Classify the offered op: funct3 legality and natural alignment.
    always_comb begin
        f3_ok = 1'b0;
        case (ex_funct3)
            F3_B, F3_H, F3_W, F3_BU, F3_HU: f3_ok = 1'b1;
            F3_D:    f3_ok = IS64;
            F3_WU:   f3_ok = IS64 && ld;
            default: f3_ok = 1'b0;
        endcase
        misal = 1'b0;
        case (ex_funct3[1:0])
            2'b01:   misal = ex_addr[0];
            2'b10:   misal = |ex_addr[1:0];
            2'b11:   misal = |ex_addr[2:0];
            default: misal = 1'b0;
        endcase
    end

    // Replicate store data of the access size across every bus lane.
    always_comb begin
        nb   = 1 << ex_funct3[1:0];
        wrep = '0;
        for (int i = 0; i < NB; i++) begin
            wrep[8*i +: 8] = ex_wdata[8*(i % nb) +: 8];
        end
    end

    load_align #(
        .XLEN(XLEN)
    ) u_align (
        .rdata_i  (bus_rdata),
        .funct3_i (f3_q),
        .off_i    (off_q),
        .data_o   (ld_data)
    );

    // Transaction FSM with all bus and writeback outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ld_q        <= 1'b0;
            f3_q        <= '0;
            off_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wmask_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_we_q     <= 1'b0;
            wb_err_q    <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (ex_valid) begin
                        wb_rd_q <= ex_rd;
                        ld_q    <= ld;
                        f3_q    <= ex_funct3;
                        off_q   <= off3;
                        if (!mem) begin
                            state_q    <= S_RESP;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b1;
                            wb_err_q   <= 1'b0;
                            wb_data_q  <= XLEN'(ex_addr);
                        end else if (!f3_ok || misal) begin
                            state_q    <= S_RESP;
                            wb_valid_q <= 1'b1;
                            wb_we_q    <= 1'b0;
                            wb_err_q   <= 1'b1;
                            wb_data_q  <= '0;
                        end else begin
                            state_q     <= S_REQ;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= ex_is_store;
                            bus_addr_q  <= ex_addr & ~ADDR_W'(NB - 1);
                            bus_wdata_q <= wrep;
                            bus_wmask_q <= NB'(lane_mask(ex_funct3[1:0], off3));
                        end
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        bus_req_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus_rvalid) begin
                        state_q    <= S_RESP;
                        wb_valid_q <= 1'b1;
                        wb_err_q   <= bus_err;
                        wb_we_q    <= ld_q & ~bus_err;
                        wb_data_q  <= ld_q ? ld_data : '0;
                    end else if (cnt_q == CNT_W'(MAX_WAIT - 1)) begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        state_q    <= S_RESP;
                        wb_valid_q <= 1'b1;
                        wb_err_q   <= 1'b1;
                        wb_we_q    <= 1'b0;
                        wb_data_q  <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    wb_valid_q <= 1'b0;
                    wb_we_q    <= 1'b0;
                    wb_err_q   <= 1'b0;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign ex_ready  = (state_q == S_IDLE);
    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_wmask = bus_wmask_q;
    assign wb_valid  = wb_valid_q;
    assign wb_we     = wb_we_q;
    assign wb_err    = wb_err_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the data width; legal values are 32 and 64.
REQ-002 Parameter ADDR_W, default 32, SHALL set the bus address width.
REQ-003 Parameter MAX_WAIT, default 16, SHALL set the number of WAIT cycles allowed before a timeout error.
REQ-004 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 rst  in  1  SHALL be the reset; asynchronous, active-high.
REQ-006 ex_valid  in  1  SHALL mark an operation offered by execute.
REQ-007 ex_ready  out  1  SHALL mark that the offered operation is accepted this cycle; the pipeline stalls while it is low.
REQ-008 ex_is_load, ex_is_store  in  1 each  SHALL give the operation class; both low means non-memory pass-through.
REQ-009 ex_funct3  in  3  SHALL give the access size and signedness.
REQ-010 ex_addr  in  ADDR_W  SHALL be the effective address; for pass-through ops it SHALL be the ALU result.
REQ-011 ex_wdata  in  XLEN  SHALL be the store data (rs2).
REQ-012 ex_rd  in  5  SHALL be the destination register.
REQ-013 wb_valid, wb_we, wb_err  out  1 each  SHALL be the result valid pulse, the register-file write enable, and the error flag.
REQ-014 wb_data  out  XLEN;  wb_rd  out  5  SHALL be the result data and destination register.
REQ-015 bus_req, bus_we  out  1 each;  bus_addr  out  ADDR_W;  bus_wdata  out  XLEN;  bus_wmask  out  XLEN/8  SHALL form the request channel.
REQ-016 bus_gnt, bus_rvalid, bus_err  in  1 each;  bus_rdata  in  XLEN  SHALL form the grant and response channel.

Function
REQ-017 The FSM SHALL have states IDLE, REQ, WAIT and RESP; ex_ready SHALL be 1 only in IDLE, and an operation is accepted when ex_valid and ex_ready are both high.
REQ-018 Pass-through op accepted: go to RESP; next cycle drive wb_valid=1, wb_we=1, wb_data=ex_addr zero-extended to XLEN.
REQ-019 Legal funct3 values: 000, 001, 010, 100 and 101; when XLEN=64, also 011 (load and store) and 110 (load only).
REQ-020 Error detection: a misaligned address (half addr[0]!=0, word addr[1:0]!=0, double addr[2:0]!=0) or an illegal funct3 SHALL issue no bus request and go to RESP with wb_err=1, wb_we=0.
REQ-021 Legal memory op: go to REQ; bus_req=1; bus_addr = ex_addr with its low log2(XLEN/8) bits cleared; bus_we = is_store.
REQ-022 All bus_* outputs SHALL be held stable while in REQ.
REQ-023 Store lanes: byte/half/word/double data SHALL be replicated across bus_wdata; bus_wmask SHALL select only the addressed lanes (e.g. SB at offset 2 -> 0100).
REQ-024 REQ -> WAIT on bus_gnt; bus_req SHALL drop in the same cycle as bus_gnt; bus_rvalid is ignored outside WAIT.
REQ-025 WAIT -> RESP on bus_rvalid, capturing bus_rdata and bus_err; stores also complete on bus_rvalid.
REQ-026 Load alignment: wb_data SHALL take the addressed lanes, sign-extended for 000/001/010 and zero-extended for 100/101/110.
REQ-027 In RESP, for one cycle: wb_valid=1; wb_err = bus_err or timeout; wb_we = load and not wb_err; then return to IDLE.
REQ-028 Timeout: a WAIT counter SHALL reset on entry to WAIT; when it reaches MAX_WAIT without bus_rvalid, go to RESP with wb_err=1.
REQ-029 Latency: pass-through and error ops complete 1 cycle after accept; memory ops complete 1 cycle after bus_rvalid.
REQ-030 At most one transaction SHALL be outstanding; a new accept can occur no earlier than the cycle after RESP.

Reset
REQ-031 While rst is high: state=IDLE, wait counter=0, and all outputs 0 except ex_ready=1.
REQ-032 Reset during REQ or WAIT SHALL drop bus_req immediately (asynchronously) and abandon the transaction, with no wb_valid.

Structure
REQ-033 Package mem_access_pkg SHALL hold the funct3 constants, the FSM state encoding and the lane-mask function.
REQ-034 Sub-module load_align SHALL be combinational and perform lane extraction and sign extension, parametrised by XLEN.

Verification
REQ-035 LW at addr 0x100, gnt after 2 cycles, rvalid 3 cycles later with rdata 0xDEADBEEF -> wb_valid, wb_we=1, wb_data=0xDEADBEEF.
REQ-036 LB at 0x103, rdata 0x80FFFFFF -> wb_data=0xFFFFFF80; LBU at the same address -> wb_data=0x00000080.
REQ-037 SH at 0x102, wdata 0x1234 -> bus_wdata=0x12341234, bus_wmask=1100, then wb_we=0, wb_err=0.
REQ-038 LW at 0x101 -> no bus_req, wb_err=1 the next cycle; rvalid never arriving with MAX_WAIT=16 -> wb_err=1 after 16 WAIT cycles.
REQ-039 rst asserted mid-WAIT -> bus_req=0 and ex_ready=1 with no wb_valid; a pass-through op with ex_addr=0x5 -> wb_data=5, wb_we=1.
